// File: rtl/core_pkg.sv
// core_pkg: payload type and lane-count helper shared by the FIFO, issue buffer and backend
package core_pkg;

    localparam int ISSUE_PAYLOAD_W = 128;
    localparam int LANE_MAX        = 32;

    typedef logic [ISSUE_PAYLOAD_W-1:0] issue_payload_t;

    // Length of the run of set bits starting at lane 0; anything above the first hole is ignored.
    function automatic int unsigned prefix_count(input logic [LANE_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < LANE_MAX; i++)
            if (v[i] && n == i) n = i + 1;
        return n;
    endfunction

endpackage

// File: rtl/core_issue_buffer_shift.sv
// core_issue_buffer_shift: drops issued entries from the bottom and appends accepted FIFO lanes
module core_issue_buffer_shift #(
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 128,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic [DATA_WIDTH-1:0]       ent_i [DEPTH],
    input  logic [CW-1:0]               rem_i,
    input  logic [CW-1:0]               n_is_i,
    input  logic [CW-1:0]               acc_i,
    input  logic [WIDTH*DATA_WIDTH-1:0] in_data_i,
    output logic [DATA_WIDTH-1:0]       ent_o [DEPTH]
);

    // Survivors move down by n_is; new lanes land directly above them; anything else holds.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_o[i] = ent_i[i];
            for (int j = 0; j < DEPTH; j++)
                if (i < int'(rem_i) && j == i + int'(n_is_i)) ent_o[i] = ent_i[j];
            for (int l = 0; l < WIDTH; l++)
                if (l < int'(acc_i) && i == int'(rem_i) + l)
                    ent_o[i] = in_data_i[l*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/core_issue_buffer.sv
// core_issue_buffer: in-order decode-to-issue staging buffer with same-cycle issue and refill
module core_issue_buffer
    import core_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = $bits(issue_payload_t)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic [WIDTH-1:0]              in_valid_i,
    input  logic [WIDTH*DATA_WIDTH-1:0]   in_data_i,
    output logic [$clog2(WIDTH+1)-1:0]    in_num_o,
    output logic [WIDTH-1:0]              is_valid_o,
    output logic [WIDTH*DATA_WIDTH-1:0]   is_data_o,
    input  logic [WIDTH-1:0]              issue_i,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(WIDTH + 1);

    if (DEPTH < WIDTH) begin : g_bad_depth
        $error("core_issue_buffer: DEPTH must be >= WIDTH");
    end

    logic [CW-1:0]         count_q, count_d, n_is, n_in, rem, space, acc;
    logic [WIDTH-1:0]      valid_q, valid_d;
    logic [DATA_WIDTH-1:0] ent_q [DEPTH];
    logic [DATA_WIDTH-1:0] ent_d [DEPTH];

    // Accept as many FIFO lanes as fit after this cycle's issue frees slots.
    always_comb begin
        n_is    = CW'(prefix_count(LANE_MAX'(issue_i & valid_q)));
        n_in    = CW'(prefix_count(LANE_MAX'(in_valid_i)));
        rem     = count_q - n_is;
        space   = CW'(DEPTH) - rem;
        acc     = (n_in < space) ? n_in : space;
        count_d = flush_i ? '0 : rem + acc;
        for (int k = 0; k < WIDTH; k++) valid_d[k] = CW'(k) < count_d;
    end

    assign in_num_o   = (flush_i || !rst_n) ? '0 : NW'(acc);
    assign is_valid_o = valid_q;
    assign count_o    = count_q;

    for (genvar k = 0; k < WIDTH; k++) begin : g_slot
        assign is_data_o[k*DATA_WIDTH +: DATA_WIDTH] = ent_q[k];
    end

    core_issue_buffer_shift #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CW         (CW)
    ) u_shift (
        .ent_i     (ent_q),
        .rem_i     (rem),
        .n_is_i    (n_is),
        .acc_i     (acc),
        .in_data_i (in_data_i),
        .ent_o     (ent_d)
    );

    // Occupancy plus a registered copy of the slot-valid mask so is_valid_o comes straight off flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            valid_q <= '0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    a_issue_valid:  assert property (@(posedge clk) disable iff (!rst_n) (issue_i & ~valid_q) == '0);
    a_issue_prefix: assert property (@(posedge clk) disable iff (!rst_n) (issue_i & (issue_i + WIDTH'(1))) == '0);
    a_in_prefix:    assert property (@(posedge clk) disable iff (!rst_n) (in_valid_i & (in_valid_i + WIDTH'(1))) == '0);

endmodule

// File: tb/tb_core_issue_buffer.sv
// tb_core_issue_buffer: directed checks on a 2x4 buffer and a queue-model soak on a 4x4 buffer
module tb_core_issue_buffer;

    logic        clk = 0;
    logic        rst_n = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic        a_flush = 0;
    logic [1:0]  a_in_valid = 0;
    logic [31:0] a_in_data = 0;
    logic [1:0]  a_in_num;
    logic [1:0]  a_is_valid;
    logic [31:0] a_is_data;
    logic [1:0]  a_issue = 0;
    logic [2:0]  a_count;

    logic        b_flush = 0;
    logic [3:0]  b_in_valid = 0;
    logic [63:0] b_in_data = 0;
    logic [2:0]  b_in_num;
    logic [3:0]  b_is_valid;
    logic [63:0] b_is_data;
    logic [3:0]  b_issue = 0;
    logic [2:0]  b_count;

    always #5 clk = ~clk;

    core_issue_buffer #(.WIDTH(2), .DEPTH(4), .DATA_WIDTH(16)) u_a (
        .clk(clk), .rst_n(rst_n), .flush_i(a_flush),
        .in_valid_i(a_in_valid), .in_data_i(a_in_data), .in_num_o(a_in_num),
        .is_valid_o(a_is_valid), .is_data_o(a_is_data), .issue_i(a_issue), .count_o(a_count)
    );

    core_issue_buffer #(.WIDTH(4), .DEPTH(4), .DATA_WIDTH(16)) u_b (
        .clk(clk), .rst_n(rst_n), .flush_i(b_flush),
        .in_valid_i(b_in_valid), .in_data_i(b_in_data), .in_num_o(b_in_num),
        .is_valid_o(b_is_valid), .is_data_o(b_is_data), .issue_i(b_issue), .count_o(b_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_a(input logic fl, input logic [1:0] iv, input logic [15:0] d0,
                           input logic [15:0] d1, input logic [1:0] is);
        a_flush = fl; a_in_valid = iv; a_in_data = {d1, d0}; a_issue = is;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    function automatic logic [3:0] pmask(input int n);
        return 4'((1 << n) - 1);
    endfunction

    logic [15:0] q[$];
    int seq = 1;

    initial begin
        #3;
        chk("rst_count", 64'(a_count), 0);
        chk("rst_valid", 64'(a_is_valid), 0);
        chk("rst_in_num", 64'(a_in_num), 0);
        @(negedge clk) rst_n = 1;
        tick();
        // fill until full
        drive_a(0, 2'b11, 1, 2, 2'b00); #4 chk("fill1_in_num", 64'(a_in_num), 2); tick();
        chk("fill1_count", 64'(a_count), 2);
        chk("fill1_valid", 64'(a_is_valid), 2'b11);
        chk("fill1_slots", 64'(a_is_data), {16'd2, 16'd1});
        drive_a(0, 2'b11, 3, 4, 2'b00); #4 chk("fill2_in_num", 64'(a_in_num), 2); tick();
        chk("fill2_count", 64'(a_count), 4);
        drive_a(0, 2'b11, 5, 6, 2'b00); #4 chk("full_in_num", 64'(a_in_num), 0); tick();
        chk("full_count", 64'(a_count), 4);
        chk("full_slots", 64'(a_is_data), {16'd2, 16'd1});
        // issue one while full: one slot refilled
        drive_a(0, 2'b11, 5, 6, 2'b01); #4 chk("iss1_in_num", 64'(a_in_num), 1); tick();
        chk("iss1_count", 64'(a_count), 4);
        chk("iss1_slots", 64'(a_is_data), {16'd3, 16'd2});
        drive_a(0, 2'b00, 0, 0, 2'b11); #4 chk("drain_in_num", 64'(a_in_num), 0); tick();
        chk("drain_count", 64'(a_count), 2);
        chk("drain_slots", 64'(a_is_data), {16'd5, 16'd4});
        drive_a(0, 2'b00, 0, 0, 2'b01); tick();
        chk("one_count", 64'(a_count), 1);
        chk("one_valid", 64'(a_is_valid), 2'b01);
        chk("one_slot0", 64'(a_is_data[15:0]), 5);
        // count 1: issue and refill one in the same cycle
        drive_a(0, 2'b01, 7, 0, 2'b01); #4 chk("swap_in_num", 64'(a_in_num), 1); tick();
        chk("swap_count", 64'(a_count), 1);
        chk("swap_slot0", 64'(a_is_data[15:0]), 7);
        drive_a(0, 2'b11, 8, 9, 2'b00); tick();
        chk("pre_flush_count", 64'(a_count), 3);
        chk("pre_flush_slots", 64'(a_is_data), {16'd8, 16'd7});
        // flush dominates issue and refill
        drive_a(1, 2'b11, 10, 11, 2'b11); #4 chk("flush_in_num", 64'(a_in_num), 0); tick();
        chk("flush_count", 64'(a_count), 0);
        chk("flush_valid", 64'(a_is_valid), 0);
        // empty: one cycle latency, no bypass
        drive_a(0, 2'b01, 12, 0, 2'b00); #4 chk("empty_valid", 64'(a_is_valid), 0); tick();
        chk("lat_count", 64'(a_count), 1);
        chk("lat_slot0", 64'(a_is_data[15:0]), 12);
        // async reset mid-stream
        drive_a(0, 2'b11, 13, 14, 2'b00); tick();
        chk("pre_rst_count", 64'(a_count), 3);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", 64'(a_is_valid), 0);
        chk("arst_in_num", 64'(a_in_num), 0);
        chk("arst_count", 64'(a_count), 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        tick();
        chk("resume_count", 64'(a_count), 2);
        chk("resume_slots", 64'(a_is_data), {16'd14, 16'd13});
        drive_a(0, 2'b00, 0, 0, 2'b00);
        // 4-wide soak against a queue model
        for (int c = 0; c < 10000; c++) begin
            int ilen, ulen, isz, rem, acc;
            logic fl;
            isz  = q.size();
            ilen = $urandom_range(0, 4);
            ulen = $urandom_range(0, isz);
            fl   = ($urandom_range(0, 49) == 0);
            b_flush    = fl;
            b_in_valid = pmask(ilen);
            for (int k = 0; k < 4; k++) b_in_data[k*16 +: 16] = 16'(seq + k);
            b_issue = pmask(ulen);
            rem = isz - ulen;
            acc = (ilen < 4 - rem) ? ilen : 4 - rem;
            #4;
            chk("soak_in_num", 64'(b_in_num), fl ? 0 : 64'(acc));
            chk("soak_valid", 64'(b_is_valid), 64'(pmask(isz)));
            for (int k = 0; k < isz; k++) chk("soak_slot", 64'(b_is_data[k*16 +: 16]), 64'(q[k]));
            tick();
            if (fl) q.delete();
            else begin
                for (int k = 0; k < ulen; k++) void'(q.pop_front());
                for (int k = 0; k < acc; k++) q.push_back(16'(seq + k));
                seq += acc;
            end
            chk("soak_count", 64'(b_count), 64'(q.size()));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
